// File: rtl/mac_dot_sequencer_if.sv
// Scheduler, operand-RAM and FP_MAC signal bundle for mac_dot_sequencer.
// FAULT exists only when MAC_SEQ_WATCHDOG_EN is defined.
interface mac_dot_sequencer_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned LEN_W  = 8
);
   logic              START;
   logic [LEN_W-1:0]  LEN;
   logic [ADDR_W-1:0] A_BASE;
   logic [ADDR_W-1:0] A_STRIDE;
   logic [ADDR_W-1:0] B_BASE;
   logic [ADDR_W-1:0] B_STRIDE;
   logic              BUSY;
   logic              DONE;
   logic [31:0]       RESULT;
   logic              MEM_A_RD;
   logic [ADDR_W-1:0] MEM_A_ADDR;
   logic [31:0]       MEM_A_DATA;
   logic              MEM_B_RD;
   logic [ADDR_W-1:0] MEM_B_ADDR;
   logic [31:0]       MEM_B_DATA;
   logic              MAC_A_VALID;
   logic              MAC_B_VALID;
   logic              MAC_C_VALID;
   logic [31:0]       MAC_A;
   logic [31:0]       MAC_B;
   logic [31:0]       MAC_C;
   logic              MAC_R_VALID;
   logic [31:0]       MAC_R;
`ifdef MAC_SEQ_WATCHDOG_EN
   logic              FAULT;
`endif

   modport master (
      input  START, LEN, A_BASE, A_STRIDE, B_BASE, B_STRIDE,
      input  MEM_A_DATA, MEM_B_DATA, MAC_R_VALID, MAC_R,
`ifdef MAC_SEQ_WATCHDOG_EN
      output FAULT,
`endif
      output BUSY, DONE, RESULT, MEM_A_RD, MEM_A_ADDR, MEM_B_RD, MEM_B_ADDR,
      output MAC_A_VALID, MAC_B_VALID, MAC_C_VALID, MAC_A, MAC_B, MAC_C
   );

   modport slave (
      output START, LEN, A_BASE, A_STRIDE, B_BASE, B_STRIDE,
      output MEM_A_DATA, MEM_B_DATA, MAC_R_VALID, MAC_R,
`ifdef MAC_SEQ_WATCHDOG_EN
      input  FAULT,
`endif
      input  BUSY, DONE, RESULT, MEM_A_RD, MEM_A_ADDR, MEM_B_RD, MEM_B_ADDR,
      input  MAC_A_VALID, MAC_B_VALID, MAC_C_VALID, MAC_A, MAC_B, MAC_C
   );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Sequences one FP_MAC through an N-element single-precision dot product fetched from two RAMs.
// Define MAC_SEQ_WATCHDOG_EN to add the WAIT_MAC watchdog and the FAULT output.
module mac_dot_sequencer #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned LEN_W       = 8,
   parameter int unsigned WDOG_CYCLES = 64
) (
   input logic                 CLK,
   input logic                 RST,
   mac_dot_sequencer_if.master bus
);
   typedef enum logic [2:0] {StIdle, StFetch, StWaitMem, StIssue, StWaitMac, StDone} state_e;

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d, cnt_inc;
   logic [ADDR_W-1:0] ptr_a_q, ptr_a_d, ptr_b_q, ptr_b_d;
   logic [ADDR_W-1:0] stride_a_q, stride_a_d, stride_b_q, stride_b_d;
   logic [31:0]       op_a_q, op_a_d, op_b_q, op_b_d, acc_q, acc_d, result_q, result_d;
`ifdef MAC_SEQ_WATCHDOG_EN
   localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
   logic [WdogW-1:0] wdog_q, wdog_d;
   logic             fault_q, fault_d;
`endif

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      ptr_a_d    = ptr_a_q;
      ptr_b_d    = ptr_b_q;
      stride_a_d = stride_a_q;
      stride_b_d = stride_b_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      acc_d      = acc_q;
      result_d   = result_q;
`ifdef MAC_SEQ_WATCHDOG_EN
      wdog_d     = wdog_q;
      fault_d    = fault_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.START) begin
`ifdef MAC_SEQ_WATCHDOG_EN
               fault_d = 1'b0;
`endif
               if (bus.LEN != '0) begin
                  len_d      = bus.LEN;
                  stride_a_d = bus.A_STRIDE;
                  stride_b_d = bus.B_STRIDE;
                  ptr_a_d    = bus.A_BASE;
                  ptr_b_d    = bus.B_BASE;
                  acc_d      = '0;
                  cnt_d      = '0;
                  state_d    = StFetch;
               end else begin
                  result_d = '0;
                  state_d  = StDone;
               end
            end
         end
         StFetch: state_d = StWaitMem;
         StWaitMem: begin
            op_a_d  = bus.MEM_A_DATA;
            op_b_d  = bus.MEM_B_DATA;
            state_d = StIssue;
         end
         StIssue: begin
`ifdef MAC_SEQ_WATCHDOG_EN
            wdog_d = '0;
`endif
            state_d = StWaitMac;
         end
         StWaitMac: begin
            if (bus.MAC_R_VALID) begin
               acc_d   = bus.MAC_R;
               cnt_d   = cnt_inc;
               ptr_a_d = ptr_a_q + stride_a_q;
               ptr_b_d = ptr_b_q + stride_b_q;
               // RESULT loads on the way into DONE so it is visible alongside the pulse.
               if (cnt_inc == len_q) begin
                  result_d = bus.MAC_R;
                  state_d  = StDone;
               end else begin
                  state_d = StFetch;
               end
            end
`ifdef MAC_SEQ_WATCHDOG_EN
            else if (wdog_q == WdogW'(WDOG_CYCLES - 1)) begin
               fault_d  = 1'b1;
               result_d = 32'h7FC0_0000;
               state_d  = StDone;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
`endif
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= StIdle;
         len_q      <= '0;
         cnt_q      <= '0;
         ptr_a_q    <= '0;
         ptr_b_q    <= '0;
         stride_a_q <= '0;
         stride_b_q <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         acc_q      <= '0;
         result_q   <= '0;
`ifdef MAC_SEQ_WATCHDOG_EN
         wdog_q     <= '0;
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         ptr_a_q    <= ptr_a_d;
         ptr_b_q    <= ptr_b_d;
         stride_a_q <= stride_a_d;
         stride_b_q <= stride_b_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
`ifdef MAC_SEQ_WATCHDOG_EN
         wdog_q     <= wdog_d;
         fault_q    <= fault_d;
`endif
      end
   end

   // Address and operand buses are zeroed outside their strobe cycle.
   always_comb begin
      bus.BUSY        = (state_q != StIdle);
      bus.DONE        = (state_q == StDone);
      bus.RESULT      = result_q;
      bus.MEM_A_RD    = (state_q == StFetch);
      bus.MEM_B_RD    = (state_q == StFetch);
      bus.MEM_A_ADDR  = (state_q == StFetch) ? ptr_a_q : '0;
      bus.MEM_B_ADDR  = (state_q == StFetch) ? ptr_b_q : '0;
      bus.MAC_A_VALID = (state_q == StIssue);
      bus.MAC_B_VALID = (state_q == StIssue);
      bus.MAC_C_VALID = (state_q == StIssue);
      bus.MAC_A       = (state_q == StIssue) ? op_a_q : '0;
      bus.MAC_B       = (state_q == StIssue) ? op_b_q : '0;
      bus.MAC_C       = (state_q == StIssue) ? acc_q : '0;
`ifdef MAC_SEQ_WATCHDOG_EN
      bus.FAULT       = fault_q;
`endif
   end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with operand RAMs and a fixed-latency FP_MAC model
// that handles small non-negative integer-valued floats.
module tb_mac_dot_sequencer;
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned LEN_W  = 8;
   localparam int unsigned LAT    = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mac_dot_sequencer_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

   mac_dot_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .WDOG_CYCLES(64)) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   function automatic int unsigned f2i(input logic [31:0] f);
      int e;
      logic [31:0] m;
      if (f[30:0] == 31'd0) return 0;
      e = int'(f[30:23]) - 127;
      m = {8'd0, 1'b1, f[22:0]};
      return m >> (23 - e);
   endfunction

   function automatic logic [31:0] i2f(input int unsigned v);
      int p;
      logic [31:0] m;
      if (v == 0) return 32'd0;
      p = 0;
      for (int i = 0; i < 32; i++) if (v[i]) p = i;
      m = v << (23 - p);
      return {1'b0, 8'(p + 127), m[22:0]};
   endfunction

   // Operand RAMs: read data valid the cycle after the strobe.
   logic [31:0] mem_a [1024];
   logic [31:0] mem_b [1024];
   always @(posedge clk) begin
      if (bus.MEM_A_RD) bus.MEM_A_DATA <= mem_a[bus.MEM_A_ADDR];
      if (bus.MEM_B_RD) bus.MEM_B_DATA <= mem_b[bus.MEM_B_ADDR];
   end

   // FP_MAC model: R_VALID high LAT cycles after the issue cycle.
   int unsigned mac_timer = 0;
   logic [31:0] mac_res = '0;
   logic        mac_dead = 1'b0;
   logic        inj_rv = 1'b0;
   logic [31:0] inj_r = '0;
   always @(posedge clk) begin
      if (mac_timer != 0) mac_timer <= mac_timer - 1;
      if (bus.MAC_A_VALID && bus.MAC_B_VALID && bus.MAC_C_VALID) begin
         mac_timer <= LAT;
         mac_res   <= i2f(f2i(bus.MAC_A) * f2i(bus.MAC_B) + f2i(bus.MAC_C));
      end
   end
   assign bus.MAC_R_VALID = inj_rv | ((mac_timer == 1) && !mac_dead);
   assign bus.MAC_R       = inj_rv ? inj_r : mac_res;

   int unsigned       done_total = 0;
   int unsigned       rd_total = 0;
   int unsigned       issue_total = 0;
   logic [31:0]       c_log[$];
   logic [ADDR_W-1:0] a_log[$];
   logic [ADDR_W-1:0] b_log[$];
   always @(negedge clk) begin
      if (bus.DONE) done_total <= done_total + 1;
      if (bus.MEM_A_RD || bus.MEM_B_RD) begin
         rd_total <= rd_total + 1;
         a_log.push_back(bus.MEM_A_ADDR);
         b_log.push_back(bus.MEM_B_ADDR);
      end
      if (bus.MAC_A_VALID || bus.MAC_B_VALID || bus.MAC_C_VALID) begin
         issue_total <= issue_total + 1;
         c_log.push_back(bus.MAC_C);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] ab,
                           input logic [ADDR_W-1:0] as, input logic [ADDR_W-1:0] bb,
                           input logic [ADDR_W-1:0] bs);
      a_log.delete();
      b_log.delete();
      c_log.delete();
      @(posedge clk); #1;
      bus.START = 1'b1; bus.LEN = len;
      bus.A_BASE = ab; bus.A_STRIDE = as; bus.B_BASE = bb; bus.B_STRIDE = bs;
      @(posedge clk); #1;
   endtask

   // Returns the cycle (1 = cycle after the START edge) in which DONE is seen, 0 on timeout.
   // disturb: during cycle 1 re-assert START, change LEN and inject a stray MAC_R_VALID.
   task automatic run_dot(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] ab,
                          input logic [ADDR_W-1:0] as, input logic [ADDR_W-1:0] bb,
                          input logic [ADDR_W-1:0] bs, input bit disturb, output int cycles);
      start_op(len, ab, as, bb, bs);
      if (disturb) begin
         bus.LEN = 8'd5;
         inj_r   = 32'h3F80_0000;
         inj_rv  = 1'b1;
      end else begin
         bus.START = 1'b0;
      end
      cycles = 0;
      for (int k = 1; k <= 2000; k++) begin
         @(negedge clk);
         if (k == 2) begin
            bus.START = 1'b0;
            inj_rv    = 1'b0;
         end
         if (bus.DONE) begin
            cycles = k;
            break;
         end
      end
      #1;
   endtask

   int          cyc;
   int unsigned d0, r0, i0;

   initial begin
      bus.START = 1'b0; bus.LEN = '0;
      bus.A_BASE = '0; bus.A_STRIDE = '0; bus.B_BASE = '0; bus.B_STRIDE = '0;
      mem_a[100] = 32'h4000_0000; mem_b[200] = 32'h4040_0000;
      mem_a[0] = 32'h3F80_0000; mem_a[1] = 32'h4000_0000; mem_a[2] = 32'h4040_0000;
      mem_b[0] = 32'h4080_0000; mem_b[1] = 32'h40A0_0000; mem_b[2] = 32'h40C0_0000;
      mem_a[1020] = 32'h4000_0000; mem_a[4] = 32'h4040_0000;
      mem_b[16] = 32'h4000_0000; mem_b[32] = 32'h3F80_0000;

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.BUSY), 32'd0);
      check("rst_done", 32'(bus.DONE), 32'd0);
      check("rst_result", bus.RESULT, 32'd0);
      check("rst_mem_rd", 32'(bus.MEM_A_RD | bus.MEM_B_RD), 32'd0);
      check("rst_mac_valid", 32'(bus.MAC_A_VALID | bus.MAC_B_VALID | bus.MAC_C_VALID), 32'd0);
`ifdef MAC_SEQ_WATCHDOG_EN
      check("rst_fault", 32'(bus.FAULT), 32'd0);
`endif
      rst = 1'b0;

      // LEN=1: 2.0 * 3.0
      d0 = done_total;
      run_dot(8'd1, 10'd100, 10'd0, 10'd200, 10'd0, 1'b0, cyc);
      check("len1_done_cycle", 32'(cyc), 32'd6);
      check("len1_result", bus.RESULT, 32'h40C0_0000);
      check("len1_issues", 32'(c_log.size()), 32'd1);
      check("len1_mac_c0", c_log[0], 32'd0);
      @(negedge clk); #1;
      check("len1_done_pulse", 32'(bus.DONE), 32'd0);
      check("len1_idle", 32'(bus.BUSY), 32'd0);
      check("len1_done_count", done_total - d0, 32'd1);

      // LEN=3 with START-while-busy, LEN change and a stray R_VALID in FETCH.
      d0 = done_total;
      run_dot(8'd3, 10'd0, 10'd1, 10'd0, 10'd1, 1'b1, cyc);
      check("len3_done_cycle", 32'(cyc), 32'd16);
      check("len3_result", bus.RESULT, 32'h4200_0000);
      check("len3_issues", 32'(c_log.size()), 32'd3);
      check("len3_mac_c0", c_log[0], 32'h0000_0000);
      check("len3_mac_c1", c_log[1], 32'h4080_0000);
      check("len3_mac_c2", c_log[2], 32'h4160_0000);
      @(negedge clk); #1;
      check("len3_done_count", done_total - d0, 32'd1);

      // LEN=0: no memory or MAC traffic, DONE in cycle 1, RESULT cleared.
      r0 = rd_total; i0 = issue_total;
      run_dot(8'd0, 10'd0, 10'd1, 10'd0, 10'd1, 1'b0, cyc);
      check("len0_done_cycle", 32'(cyc), 32'd1);
      check("len0_result", bus.RESULT, 32'd0);
      check("len0_reads", rd_total - r0, 32'd0);
      check("len0_issues", issue_total - i0, 32'd0);

      // Address wrap on A, column stride on B: 2*4 + 1*2 + 3*1 = 13.
      run_dot(8'd3, 10'd1020, 10'd4, 10'd0, 10'd16, 1'b0, cyc);
      check("wrap_a0", 32'(a_log[0]), 32'd1020);
      check("wrap_a1", 32'(a_log[1]), 32'd0);
      check("wrap_a2", 32'(a_log[2]), 32'd4);
      check("wrap_b0", 32'(b_log[0]), 32'd0);
      check("wrap_b1", 32'(b_log[1]), 32'd16);
      check("wrap_b2", 32'(b_log[2]), 32'd32);
      check("wrap_result", bus.RESULT, 32'h4150_0000);

      // Reset during the second WAIT_MAC (cycle 9 with LAT=2).
      start_op(8'd3, 10'd0, 10'd1, 10'd0, 10'd1);
      bus.START = 1'b0;
      d0 = done_total;
      repeat (9) @(negedge clk);
      check("abort_in_2nd_wait", 32'(c_log.size()), 32'd2);
      check("abort_busy_pre", 32'(bus.BUSY), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(bus.BUSY), 32'd0);
      check("abort_valids", 32'(bus.MAC_A_VALID | bus.MAC_B_VALID | bus.MAC_C_VALID), 32'd0);
      check("abort_result", bus.RESULT, 32'd0);
      check("abort_done", 32'(bus.DONE), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("abort_no_done", done_total - d0, 32'd0);
      run_dot(8'd3, 10'd0, 10'd1, 10'd0, 10'd1, 1'b0, cyc);
      check("after_abort_result", bus.RESULT, 32'h4200_0000);
      check("after_abort_cycle", 32'(cyc), 32'd16);

`ifdef MAC_SEQ_WATCHDOG_EN
      // Dead MAC: 64 cycles in WAIT_MAC (cycles 4..67), DONE in cycle 68.
      mac_dead = 1'b1;
      run_dot(8'd1, 10'd100, 10'd0, 10'd200, 10'd0, 1'b0, cyc);
      check("wdog_done_cycle", 32'(cyc), 32'd68);
      check("wdog_fault", 32'(bus.FAULT), 32'd1);
      check("wdog_result", bus.RESULT, 32'h7FC0_0000);
      @(negedge clk); #1;
      check("wdog_fault_sticky", 32'(bus.FAULT), 32'd1);
      mac_dead = 1'b0;
      run_dot(8'd1, 10'd100, 10'd0, 10'd200, 10'd0, 1'b0, cyc);
      check("wdog_fault_cleared", 32'(bus.FAULT), 32'd0);
      check("wdog_recover_result", bus.RESULT, 32'h40C0_0000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
